uart_rx_frame: RTL and testbench

Serial receive front end for the RS-232 DCE port on the 50 MHz board. It synchronises `RS232_DCE_RXD`, detects and validates start bits, oversamples each bit with a majority vote, and reassembles 8-bit LSB-first frames. Each completed byte is presented to the downstream UART test/application logic through a one-entry valid/ready holding register. Framing and overrun errors are flagged.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_baud_tick.sv | 36 +++
 rtl/uart_rx_frame.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions (FSM states, frame width, divider and vote helpers).
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd5,
`endif
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

  // Rounded clocks-per-sample-tick divider.
  function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
    return (clk_hz + (baud * oversample) / 2) / (baud * oversample);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: emits a one-cycle tick every DIV clocks; restart_i realigns the phase.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          tick_q;

  // Divider counter; tick is registered so it is glitch-free for every consumer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= {CW{1'b0}};
      tick_q <= 1'b0;
    end else if (restart_i) begin
      cnt_q  <= {CW{1'b0}};
      tick_q <= 1'b0;
    end else if (cnt_q == LAST) begin
      cnt_q  <= {CW{1'b0}};
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + CW'(1);
      tick_q <= 1'b0;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: RS-232 receiver, 8N1 by default, 8E1 with PARITY_ERR output when
// UART_RX_PARITY_EN is defined. Bytes leave through a one-entry valid/ready register.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 CLK_50MHZ,
  input  logic                 RST_N,
  input  logic                 RS232_DCE_RXD,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 VALID,
  input  logic                 READY,
  output logic                 FRAME_ERR,
`ifdef UART_RX_PARITY_EN
  output logic                 PARITY_ERR,
`endif
  output logic                 OVERRUN
);

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [SW-1:0] S_LO     = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID    = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_HI     = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_END    = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic [1:0]           sync_q;
  logic                 prev_q;
  logic [1:0]           settle_q;
  logic                 armed_q;
  uart_state_e          state_q;
  logic [SW-1:0]        samp_q;
  logic [BW-1:0]        bit_q;
  logic [1:0]           votes_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 ovr_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q;
  logic                 perr_q;
`endif

  logic rxd_s, fall_s, start_s, tick_s, vote_s, vote_tick_s, end_tick_s, deliver_s;

  assign rxd_s       = sync_q[1];
  assign fall_s      = armed_q & prev_q & ~rxd_s;
  assign start_s     = (state_q == ST_IDLE) & fall_s;
  assign vote_s      = maj3(votes_q[1], votes_q[0], rxd_s);
  assign vote_tick_s = tick_s & (samp_q == S_HI);
  assign end_tick_s  = tick_s & (samp_q == S_END);
`ifdef UART_RX_PARITY_EN
  assign deliver_s   = vote_tick_s & (state_q == ST_STOP) & vote_s & ~par_bad_q;
`else
  assign deliver_s   = vote_tick_s & (state_q == ST_STOP) & vote_s;
`endif

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk_i     (CLK_50MHZ),
    .rst_ni    (RST_N),
    .restart_i (start_s),
    .tick_o    (tick_s)
  );

  // Synchroniser; a line already low after reset must rise before a start edge counts.
  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      sync_q   <= 2'b11;
      prev_q   <= 1'b1;
      settle_q <= 2'd0;
      armed_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], RS232_DCE_RXD};
      prev_q <= rxd_s;
      if (settle_q != 2'd2) settle_q <= settle_q + 2'd1;
      if ((settle_q == 2'd2) && rxd_s) armed_q <= 1'b1;
    end
  end

  // Frame FSM with in-bit sample counter and three-sample vote.
  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      samp_q  <= {SW{1'b0}};
      bit_q   <= {BW{1'b0}};
      votes_q <= 2'b11;
      shift_q <= {DATA_BITS{1'b0}};
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q <= 1'b0;
`endif
      if (tick_s) begin
        samp_q <= (samp_q == S_END) ? {SW{1'b0}} : samp_q + SW'(1);
        if (samp_q == S_LO)  votes_q[1] <= rxd_s;
        if (samp_q == S_MID) votes_q[0] <= rxd_s;
      end
      case (state_q)
        ST_IDLE: begin
          if (start_s) begin
            state_q <= ST_START;
            samp_q  <= {SW{1'b0}};
            bit_q   <= {BW{1'b0}};
          end
        end
        ST_START: begin
          if (vote_tick_s && vote_s) state_q <= ST_IDLE;
          else if (end_tick_s)       state_q <= ST_DATA;
        end
        ST_DATA: begin
          if (vote_tick_s) shift_q <= {vote_s, shift_q[DATA_BITS-1:1]};
          if (end_tick_s) begin
            bit_q <= bit_q + BW'(1);
`ifdef UART_RX_PARITY_EN
            if (bit_q == LAST_BIT) state_q <= ST_PARITY;
`else
            if (bit_q == LAST_BIT) state_q <= ST_STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (vote_tick_s) par_bad_q <= vote_s ^ (^shift_q);
          if (end_tick_s)  state_q   <= ST_STOP;
        end
`endif
        ST_STOP: begin
          // Leave at mid-bit so a zero-idle start edge is still caught.
          if (vote_tick_s) begin
`ifdef UART_RX_PARITY_EN
            perr_q <= par_bad_q;
`endif
            if (vote_s) begin
              state_q <= ST_IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          if (rxd_s) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // One-entry holding register: load when empty or being drained, else flag overrun.
  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      data_q  <= {DATA_BITS{1'b0}};
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (deliver_s) begin
        if (!valid_q || READY) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (READY) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign DATA      = data_q;
  assign VALID     = valid_q;
  assign FRAME_ERR = ferr_q;
  assign OVERRUN   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign PARITY_ERR = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed test of uart_rx_frame at 115200 baud on a 50 MHz clock.
// Frames carry an even-parity bit when UART_RX_PARITY_EN is defined.
module tb_uart_rx_frame;

  localparam int BIT = 434;  // true 115200-baud bit time in 50 MHz clocks
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Stop-vote clock after the start edge: 3-clock sync/detect, 27-clock ticks, 10th tick of stop bit.
  localparam int VOTE_CLK = 27 * (16 * (NBITS - 1) + 10) + 4;
  localparam int LAT_NOM  = 4107 + (NBITS - 10) * 432;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       ferr;
  logic       ovr;
`ifdef UART_RX_PARITY_EN
  logic       perr;
  logic       par_flip = 1'b0;
  int         perr_cnt = 0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int vhi_cnt = 0;
  int vlo_cnt = 0;
  logic [7:0] last_data = 8'h00;

  always #10 clk = ~clk;

  uart_rx_frame dut (
    .CLK_50MHZ     (clk),
    .RST_N         (rst_n),
    .RS232_DCE_RXD (rxd),
    .DATA          (data),
    .VALID         (valid),
    .READY         (ready),
    .FRAME_ERR     (ferr),
`ifdef UART_RX_PARITY_EN
    .PARITY_ERR    (perr),
`endif
    .OVERRUN       (ovr)
  );

  always @(negedge clk) begin
    if (ferr) ferr_cnt <= ferr_cnt + 1;
    if (ovr)  ovr_cnt  <= ovr_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (perr) perr_cnt <= perr_cnt + 1;
`endif
    if (valid) begin
      vhi_cnt   <= vhi_cnt + 1;
      last_data <= data;
    end else begin
      vlo_cnt <= vlo_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start edge lands #1 after the first posedge; ends #1 after the stop bit, line high.
  task automatic send_frame(input logic [7:0] b, input logic stop_b);
    @(posedge clk);
    #1 rxd = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rxd = b[i];
      repeat (BIT) @(posedge clk);
    end
`ifdef UART_RX_PARITY_EN
    #1 rxd = (^b) ^ par_flip;
    repeat (BIT) @(posedge clk);
`endif
    #1 rxd = stop_b;
    repeat (BIT) @(posedge clk);
    #1 rxd = 1'b1;
  endtask

  initial begin
    int bf, bo, bv, bl, lat;
    logic [7:0] got;
`ifdef UART_RX_PARITY_EN
    int bp;
`endif
    rst_n = 1'b0;
    rxd   = 1'b1;
    ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_data", data, 8'h00);
    check("reset_valid", valid, 1'b0);
    check("reset_frame_err", ferr, 1'b0);
    check("reset_overrun", ovr, 1'b0);
    repeat (10) @(posedge clk);

    // Single byte 0x55, consumer always ready.
    ready = 1'b1;
    bf = ferr_cnt; bo = ovr_cnt; bv = vhi_cnt;
    lat = 0; got = 8'h00;
    fork
      send_frame(8'h55, 1'b1);
      begin
        @(posedge clk);
        #1;
        for (int i = 1; i <= 6000; i++) begin
          @(posedge clk);
          #1;
          if (valid) begin
            lat = i;
            got = data;
            break;
          end
        end
      end
    join
    repeat (20) @(posedge clk);
    #1;
    n_cmp++;
    assert ((lat >= LAT_NOM - 80) && (lat <= LAT_NOM + 80)) else begin
      n_bad++;
      $error("FAIL latency: observed %0d expected %0d +/- 80", lat, LAT_NOM);
    end
    check("byte55_data", got, 8'h55);
    check("byte55_valid_cycles", vhi_cnt - bv, 1);
    check("byte55_frame_err", ferr_cnt - bf, 0);
    check("byte55_overrun", ovr_cnt - bo, 0);

    // 108-clock low glitch on an idle line.
    bf = ferr_cnt; bv = vhi_cnt;
    @(posedge clk);
    #1 rxd = 1'b0;
    repeat (108) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (600) @(posedge clk);
    #1;
    check("glitch_no_valid", vhi_cnt - bv, 0);
    check("glitch_no_frame_err", ferr_cnt - bf, 0);

    // Framing error on 0xA3, then a good 0x3C.
    bf = ferr_cnt; bo = ovr_cnt; bv = vhi_cnt;
    send_frame(8'hA3, 1'b0);
    repeat (BIT) @(posedge clk);
    #1;
    check("frame_err_pulses", ferr_cnt - bf, 1);
    check("frame_err_no_valid", vhi_cnt - bv, 0);
    check("frame_err_no_overrun", ovr_cnt - bo, 0);
    send_frame(8'h3C, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    check("after_ferr_valid_cycles", vhi_cnt - bv, 1);
    check("after_ferr_data", last_data, 8'h3C);
    check("after_ferr_frame_err", ferr_cnt - bf, 1);

    // Overrun: 0x11 then 0x22 back-to-back, consumer stalled.
    ready = 1'b0;
    bf = ferr_cnt; bo = ovr_cnt;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    check("overrun_valid", valid, 1'b1);
    check("overrun_data_kept", data, 8'h11);
    check("overrun_pulses", ovr_cnt - bo, 1);
    check("overrun_no_frame_err", ferr_cnt - bf, 0);
    ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
    check("overrun_drained", valid, 1'b0);

    // Load on accept: READY only in the cycle the second byte lands.
    bo = ovr_cnt;
    send_frame(8'h11, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    check("loa_first_valid", valid, 1'b1);
    check("loa_first_data", data, 8'h11);
    bl = vlo_cnt;
    fork
      send_frame(8'h22, 1'b1);
      begin
        @(posedge clk);
        #1;
        repeat (VOTE_CLK - 1) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
      end
    join
    repeat (5) @(posedge clk);
    #1;
    check("loa_valid", valid, 1'b1);
    check("loa_data", data, 8'h22);
    check("loa_no_overrun", ovr_cnt - bo, 0);
    check("loa_valid_never_low", vlo_cnt - bl, 0);

    // Reset during data bit 4 of 0xFF while 0x22 is still held.
    bf = ferr_cnt; bo = ovr_cnt;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        @(posedge clk);
        #1;
        repeat (5 * BIT + 200) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_data", data, 8'h00);
        check("midrst_valid", valid, 1'b0);
        check("midrst_frame_err", ferr, 1'b0);
        check("midrst_overrun", ovr, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
      end
    join
    repeat (600) @(posedge clk);
    #1;
    check("postrst_no_delivery", valid, 1'b0);
    check("postrst_data", data, 8'h00);
    check("postrst_no_errors", (ferr_cnt - bf) + (ovr_cnt - bo), 0);

`ifdef UART_RX_PARITY_EN
    // 0x07 with odd parity: byte dropped, PARITY_ERR once.
    ready = 1'b1;
    bp = perr_cnt; bv = vhi_cnt; bf = ferr_cnt;
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    par_flip = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("parity_err_pulses", perr_cnt - bp, 1);
    check("parity_no_valid", vhi_cnt - bv, 0);
    check("parity_no_frame_err", ferr_cnt - bf, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
